rs232_avm_slave: RTL and testbench

Avalon-MM slave that fronts an 8N1 RS232 UART and gives the Rsa256Wrapper master its byte stream. It implements the RXDATA/TXDATA/STATUS register map the wrapper polls, and serialises/deserialises bytes on `rs232_txd`/`rs232_rxd`. It sits between the wrapper's Avalon port and the board's UART pins, and replaces the bench-only slave model in synthesis.

---
 rtl/rs232_pkg.sv | 28 ++
 rtl/rs232_avm_slave_if.sv | 12 +
 rtl/rs232_rx.sv | 94 +++++++++
 rtl/rs232_avm_slave.sv | 186 ++++++++++++++++++
 tb/tb_rs232_avm_slave.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rs232_pkg.sv
// Register map, status bit positions and FSM encodings shared by the RS232 Avalon-MM slave.
package rs232_pkg;

  localparam logic [4:0] ADDR_RX   = 5'd0;
  localparam logic [4:0] ADDR_TX   = 5'd4;
  localparam logic [4:0] ADDR_STAT = 5'd8;

  localparam int STAT_RX_VALID  = 7;
  localparam int STAT_TX_EMPTY  = 6;
  localparam int STAT_OVERRUN   = 1;
  localparam int STAT_FRAME_ERR = 0;

  typedef enum logic [1:0] {BUS_IDLE, BUS_WAIT, BUS_ACK} bus_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  function automatic logic [31:0] status_word(input logic rx_valid, input logic tx_empty,
                                              input logic overrun, input logic frame_err);
    logic [31:0] w;
    w = '0;
    w[STAT_RX_VALID]  = rx_valid;
    w[STAT_TX_EMPTY]  = tx_empty;
    w[STAT_OVERRUN]   = overrun;
    w[STAT_FRAME_ERR] = frame_err;
    return w;
  endfunction

endpackage

// File: rtl/rs232_avm_slave_if.sv
// Avalon-MM bus between the wrapper master and the RS232 slave.
interface rs232_avm_slave_if;
  logic [4:0]  address;
  logic        read;
  logic [31:0] readdata;
  logic        write;
  logic [31:0] writedata;
  logic        waitrequest;

  modport master (output address, read, write, writedata, input readdata, waitrequest);
  modport slave  (input address, read, write, writedata, output readdata, waitrequest);
endinterface

// File: rtl/rs232_rx.sv
// 8N1 receiver: input synchroniser, half-bit start qualification, LSB-first deserializer.
// state    | meaning
// RX_IDLE  | line idle, waiting for a falling edge
// RX_START | counting to mid start bit; line high there means a glitch
// RX_DATA  | sampling d0..d7 once per bit period
// RX_STOP  | sampling the stop bit; emits done or frame_err
module rs232_rx
  import rs232_pkg::*;
#(
  parameter int CLK_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] byte_o,
  output logic       done_o,
  output logic       frame_err_o
);

  localparam int TW = $clog2(CLK_DIV);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLK_DIV / 2 - 1);

  logic          sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  rx_state_e     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tc;

  always_comb begin
    sync1_d     = rxd;
    sync2_d     = sync1_q;
    prev_d      = sync2_q;
    state_d     = state_q;
    timer_d     = timer_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    done_o      = 1'b0;
    frame_err_o = 1'b0;
    tc          = (timer_q == '0);
    if (!tc) timer_d = timer_q - 1'b1;
    case (state_q)
      RX_IDLE: if (prev_q && !sync2_q) begin
        state_d = RX_START;
        timer_d = HALF_LAST;
      end
      RX_START: if (tc) begin
        if (!sync2_q) begin
          state_d = RX_DATA;
          timer_d = BIT_LAST;
          bit_d   = '0;
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_DATA: if (tc) begin
        shift_d = {sync2_q, shift_q[7:1]};
        timer_d = BIT_LAST;
        if (bit_q == 3'd7) state_d = RX_STOP;
        else               bit_d   = bit_q + 1'b1;
      end
      RX_STOP: if (tc) begin
        done_o      = sync2_q;
        frame_err_o = ~sync2_q;
        state_d     = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_o = shift_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/rs232_avm_slave.sv
// Avalon-MM slave exposing RXDATA/TXDATA/STATUS over an 8N1 UART, with the TX shifter inline.
// state    | meaning
// BUS_IDLE | no access in progress
// BUS_WAIT | access stalled on rx_valid or a full TX holding register
// BUS_ACK  | waitrequest low, access accepted this cycle
// TX_IDLE  | shifter idle, txd high
// TX_START | driving start bit
// TX_DATA  | driving d0..d7
// TX_STOP  | driving stop bit; hands off the next byte without a gap
module rs232_avm_slave
  import rs232_pkg::*;
#(
  parameter int CLK_DIV = 434
) (
  input  logic             avm_clk,
  input  logic             avm_rst_n,
  rs232_avm_slave_if.slave avm,
  input  logic             rs232_rxd,
  output logic             rs232_txd
);

  localparam int TW = $clog2(CLK_DIV);
  localparam logic [TW-1:0] BIT_LAST = TW'(CLK_DIV - 1);

  bus_state_e    bus_state_q, bus_state_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [7:0]    rx_byte_q, rx_byte_d, tx_hold_q, tx_hold_d, tx_shift_q, tx_shift_d;
  logic          rx_valid_q, rx_valid_d, overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic          tx_empty_q, tx_empty_d, txd_q, txd_d;
  tx_state_e     tx_state_q, tx_state_d;
  logic [TW-1:0] tx_timer_q, tx_timer_d;
  logic [2:0]    tx_bit_q, tx_bit_d;

  logic       req_rd, req_wr, sel_rx, sel_tx, sel_stat, ready;
  logic       acc_rx, acc_tx, acc_stat, tx_load, tx_tc;
  logic [7:0] rx_byte;
  logic       rx_done, rx_ferr;
  logic       unused_wdata;

  rs232_rx #(.CLK_DIV(CLK_DIV)) u_rx (
    .clk        (avm_clk),
    .rst_n      (avm_rst_n),
    .rxd        (rs232_rxd),
    .byte_o     (rx_byte),
    .done_o     (rx_done),
    .frame_err_o(rx_ferr)
  );

  assign req_rd   = avm.read & ~avm.write;
  assign req_wr   = avm.write & ~avm.read;
  assign sel_rx   = (avm.address == ADDR_RX);
  assign sel_tx   = (avm.address == ADDR_TX);
  assign sel_stat = (avm.address == ADDR_STAT);
  assign ready    = (req_rd & (~sel_rx | rx_valid_q)) | (req_wr & (~sel_tx | tx_empty_q));
  assign acc_rx   = (bus_state_q == BUS_ACK) & req_rd & sel_rx;
  assign acc_tx   = (bus_state_q == BUS_ACK) & req_wr & sel_tx;
  assign acc_stat = (bus_state_q == BUS_ACK) & req_rd & sel_stat;
  assign unused_wdata = ^avm.writedata[31:8];

  always_comb begin
    bus_state_d = bus_state_q;
    rdata_d     = '0;
    case (bus_state_q)
      BUS_IDLE, BUS_WAIT: begin
        if (!(req_rd | req_wr)) begin
          bus_state_d = BUS_IDLE;
        end else if (ready) begin
          bus_state_d = BUS_ACK;
          if (req_rd)
            rdata_d = sel_rx   ? {24'b0, rx_byte_q} :
                      sel_stat ? status_word(rx_valid_q, tx_empty_q, overrun_q, frame_err_q) :
                                 32'b0;
        end else begin
          bus_state_d = BUS_WAIT;
        end
      end
      default: bus_state_d = BUS_IDLE;
    endcase

    // Only clear the error bits that the master actually saw in this STATUS read.
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = rx_valid_q & ~acc_rx;
    overrun_d   = overrun_q & ~(acc_stat & rdata_q[STAT_OVERRUN]);
    frame_err_d = frame_err_q & ~(acc_stat & rdata_q[STAT_FRAME_ERR]);
    if (rx_ferr) frame_err_d = 1'b1;
    if (rx_done) begin
      if (rx_valid_d) begin
        overrun_d = 1'b1;
      end else begin
        rx_byte_d  = rx_byte;
        rx_valid_d = 1'b1;
      end
    end

    tx_hold_d  = tx_hold_q;
    tx_empty_d = tx_empty_q;
    if (acc_tx) begin
      tx_hold_d  = avm.writedata[7:0];
      tx_empty_d = 1'b0;
    end
    if (tx_load) tx_empty_d = 1'b1;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_timer_d = tx_timer_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    tx_load    = 1'b0;
    tx_tc      = (tx_timer_q == '0);
    if (!tx_tc) tx_timer_d = tx_timer_q - 1'b1;
    case (tx_state_q)
      TX_IDLE: begin
        txd_d   = 1'b1;
        tx_load = ~tx_empty_q;
      end
      TX_START: if (tx_tc) begin
        tx_state_d = TX_DATA;
        tx_timer_d = BIT_LAST;
        tx_bit_d   = '0;
        txd_d      = tx_shift_q[0];
        tx_shift_d = {1'b0, tx_shift_q[7:1]};
      end
      TX_DATA: if (tx_tc) begin
        tx_timer_d = BIT_LAST;
        if (tx_bit_q == 3'd7) begin
          tx_state_d = TX_STOP;
          txd_d      = 1'b1;
        end else begin
          tx_bit_d   = tx_bit_q + 1'b1;
          txd_d      = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
        end
      end
      TX_STOP: if (tx_tc) begin
        tx_load = ~tx_empty_q;
        if (tx_empty_q) tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
    if (tx_load) begin
      tx_state_d = TX_START;
      tx_timer_d = BIT_LAST;
      tx_shift_d = tx_hold_q;
      txd_d      = 1'b0;
    end
  end

  assign avm.waitrequest = (bus_state_q != BUS_ACK);
  assign avm.readdata    = rdata_q;
  assign rs232_txd       = txd_q;

  always_ff @(posedge avm_clk) begin
    if (!avm_rst_n) begin
      bus_state_q <= BUS_IDLE;
      rdata_q     <= '0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      tx_hold_q   <= '0;
      tx_empty_q  <= 1'b1;
      tx_state_q  <= TX_IDLE;
      tx_timer_q  <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      txd_q       <= 1'b1;
    end else begin
      bus_state_q <= bus_state_d;
      rdata_q     <= rdata_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      tx_hold_q   <= tx_hold_d;
      tx_empty_q  <= tx_empty_d;
      tx_state_q  <= tx_state_d;
      tx_timer_q  <= tx_timer_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      txd_q       <= txd_d;
    end
  end

endmodule

// File: tb/tb_rs232_avm_slave.sv
// Directed bench for rs232_avm_slave at CLK_DIV=4: bus timing, TX framing, RX status/errors, reset.
module tb_rs232_avm_slave;
  import rs232_pkg::*;

  localparam int DIV  = 4;
  localparam int HIST = 8192;
  localparam int TMO  = 400;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rxd = 1'b1;
  logic txd;

  rs232_avm_slave_if bus ();

  rs232_avm_slave #(.CLK_DIV(DIV)) dut (
    .avm_clk  (clk),
    .avm_rst_n(rst_n),
    .avm      (bus),
    .rs232_rxd(rxd),
    .rs232_txd(txd)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  logic txd_hist [HIST];
  logic wr_hist  [HIST];

  always @(posedge clk) cyc = cyc + 1;
  always @(negedge clk) begin
    if (cyc < HIST) begin
      txd_hist[cyc] = txd;
      wr_hist[cyc]  = bus.waitrequest;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_rd(input logic [4:0] a, output logic [31:0] d, output int wait_n, output int acc);
    bus.address = a;
    bus.read    = 1'b1;
    bus.write   = 1'b0;
    d = '0; wait_n = 0; acc = -1;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (bus.waitrequest === 1'b0) begin
        d   = bus.readdata;
        acc = cyc;
        break;
      end
      wait_n++;
    end
    @(posedge clk); #1;
    bus.read = 1'b0;
    chk("rd_done", {31'b0, acc >= 0}, 32'd1);
  endtask

  task automatic bus_wr(input logic [4:0] a, input logic [7:0] v, output int wait_n, output int acc);
    bus.address   = a;
    bus.writedata = {24'hFFFFFF, v};
    bus.write     = 1'b1;
    bus.read      = 1'b0;
    wait_n = 0; acc = -1;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (bus.waitrequest === 1'b0) begin
        acc = cyc;
        break;
      end
      wait_n++;
    end
    @(posedge clk); #1;
    bus.write = 1'b0;
    chk("wr_done", {31'b0, acc >= 0}, 32'd1);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rxd = fr[k];
      repeat (DIV) @(posedge clk);
      #1;
    end
    rxd = 1'b1;
  endtask

  task automatic chk_frame(input string tag, input int s, input logic [7:0] b);
    logic [9:0] fr;
    logic [3:0] seen;
    int idx;
    fr = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < DIV; j++) begin
        idx = s + DIV * k + j;
        seen[j] = (idx >= 0 && idx < HIST) ? txd_hist[idx] : 1'bx;
      end
      chk($sformatf("%s_bit%0d", tag, k), {28'b0, seen}, {28'b0, {4{fr[k]}}});
    end
  endtask

  initial begin
    logic [31:0] d;
    int w, a, a1, a2, a3, c0, acc, zeros;

    bus.address = '0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;

    // reset state
    step(3);
    @(negedge clk);
    chk("rst_waitreq", {31'b0, bus.waitrequest}, 32'd1);
    chk("rst_readdata", bus.readdata, 32'd0);
    chk("rst_txd", {31'b0, txd}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(2);

    bus_rd(ADDR_STAT, d, w, a);
    chk("stat_reset", d, 32'h40);
    chk("stat_wait", w, 32'd1);

    // unmapped accesses
    bus_rd(5'd12, d, w, a);
    chk("unmapped_rd", d, 32'h0);
    chk("unmapped_rd_wait", w, 32'd1);
    bus_wr(5'd16, 8'hFF, w, a);
    chk("unmapped_wr_wait", w, 32'd1);
    step(2);
    bus_rd(ADDR_STAT, d, w, a);
    chk("stat_after_unmapped", d, 32'h40);

    // protocol error: read and write together never accepted
    bus.address = ADDR_STAT; bus.read = 1'b1; bus.write = 1'b1;
    c0 = cyc;
    step(8);
    bus.read = 1'b0; bus.write = 1'b0;
    zeros = 0;
    for (int i = c0; i < c0 + 8; i++) if (wr_hist[i] !== 1'b1) zeros++;
    chk("rw_both_no_accept", zeros, 32'd0);
    step(2);

    // single TX byte
    bus_wr(ADDR_TX, 8'hA5, w, a);
    chk("tx_wr_wait", w, 32'd1);
    step(1);
    bus_rd(ADDR_STAT, d, w, acc);
    chk("stat_after_handoff", d, 32'h40);
    step(50);
    chk("tx_idle_before_start", {31'b0, txd_hist[a + 1]}, 32'd1);
    chk_frame("a5", a + 2, 8'hA5);
    chk("tx_idle_after_a5", {31'b0, txd_hist[a + 42]}, 32'd1);

    // three back-to-back TX writes
    bus_wr(ADDR_TX, 8'h12, w, a1);
    bus_wr(ADDR_TX, 8'h34, w, a2);
    bus_wr(ADDR_TX, 8'h56, w, a3);
    chk("tx2_accept", a2 - a1, 32'd3);
    chk("tx3_stall", a3 - a1, 32'd43);
    step(90);
    chk_frame("f12", a1 + 2, 8'h12);
    chk_frame("f34", a1 + 42, 8'h34);
    chk_frame("f56", a1 + 82, 8'h56);
    chk("tx_idle_after_56", {31'b0, txd_hist[a1 + 122]}, 32'd1);

    // RX one byte
    send_rx(8'h3C, 1'b1);
    step(8);
    bus_rd(ADDR_STAT, d, w, a);
    chk("stat_rx_valid", d, 32'hC0);
    bus_rd(ADDR_RX, d, w, a);
    chk("rx_3c", d, 32'h3C);
    chk("rx_3c_wait", w, 32'd1);
    bus_rd(ADDR_STAT, d, w, a);
    chk("stat_rx_cleared", d, 32'h40);

    // RXDATA read pending before the byte arrives
    bus.address = ADDR_RX; bus.read = 1'b1;
    c0 = cyc;
    send_rx(8'h7E, 1'b1);
    acc = -1; d = '0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (bus.waitrequest === 1'b0) begin
        d = bus.readdata;
        acc = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    bus.read = 1'b0;
    zeros = 0;
    for (int i = c0; i < c0 + 40; i++) if (wr_hist[i] !== 1'b1) zeros++;
    chk("rx_pend_hold", zeros, 32'd0);
    chk("rx_pend_data", d, 32'h7E);
    chk("rx_pend_timing", {31'b0, (acc >= c0 + 40) && (acc <= c0 + 42)}, 32'd1);
    step(4);
    bus_rd(ADDR_STAT, d, w, a);
    chk("stat_after_pend", d, 32'h40);

    // good, bad-stop, good: frame_err then overrun
    send_rx(8'h11, 1'b1);
    step(8);
    send_rx(8'h22, 1'b0);
    step(8);
    send_rx(8'h33, 1'b1);
    step(8);
    bus_rd(ADDR_STAT, d, w, a);
    chk("stat_errors", d, 32'hC3);
    bus_rd(ADDR_RX, d, w, a);
    chk("rx_kept_first", d, 32'h11);
    bus_rd(ADDR_STAT, d, w, a);
    chk("stat_errors_cleared", d, 32'h40);

    // 2-cycle glitch must not start a frame
    rxd = 1'b0;
    step(2);
    rxd = 1'b1;
    step(60);
    bus_rd(ADDR_STAT, d, w, a);
    chk("stat_after_glitch", d, 32'h40);

    // reset in the middle of a frame
    bus_wr(ADDR_TX, 8'h00, w, a);
    step(8);
    @(negedge clk);
    chk("tx_mid_frame_low", {31'b0, txd}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("tx_reset_high", {31'b0, txd}, 32'd1);
    chk("reset_waitreq", {31'b0, bus.waitrequest}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(2);
    bus_rd(ADDR_STAT, d, w, a);
    chk("stat_after_reset", d, 32'h40);
    step(20);
    chk("txd_idle_after_reset", {31'b0, txd}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
